// File: rtl/fetch_unit_if.sv
// Bus between fetch_unit, instruction memory, execute (redirect) and the decoder.
interface fetch_unit_if;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready;
    logic [31:0] io_imem_req_addr;
    logic        io_imem_resp_valid;
    logic [31:0] io_imem_resp_data;
    logic        io_redirect_valid;
    logic [31:0] io_redirect_pc;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_out_inst;
    logic [31:0] io_out_pc;

    modport master (
        output io_imem_req_valid, io_imem_req_addr,
        output io_out_valid, io_out_inst, io_out_pc,
        input  io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data,
        input  io_redirect_valid, io_redirect_pc, io_out_ready
    );

    modport slave (
        input  io_imem_req_valid, io_imem_req_addr,
        input  io_out_valid, io_out_inst, io_out_pc,
        output io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data,
        output io_redirect_valid, io_redirect_pc, io_out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited in-order memory requests, {pc,inst} buffer
// towards the decoder, and redirect flush with dropping of in-flight responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic         clock,
    input logic         reset,
    fetch_unit_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   buf_pc_q   [DEPTH];
    logic [31:0]   buf_inst_q [DEPTH];

    logic          out_valid, deq, req_valid, req_fire, resp_fire, enq;
    logic [CW:0]   credit;
    logic [31:0]   redir_pc;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        redir_pc  = {bus.io_redirect_pc[31:2], 2'b00};
        out_valid = (occ_q != '0);
        deq       = out_valid & bus.io_out_ready;
        // Entries already owed to the buffer plus those still stored; a dequeue frees one now.
        credit    = {1'b0, outst_q} + {1'b0, occ_q} - {{CW{1'b0}}, deq};
        req_valid = reset & ~bus.io_redirect_valid & (credit < DEPTH_W);
        req_fire  = req_valid & bus.io_imem_req_ready;
        resp_fire = bus.io_imem_resp_valid & (outst_q != '0);
        enq       = resp_fire & ~bus.io_redirect_valid & (drop_q == '0);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(resp_fire);
        drop_d     = drop_q;
        occ_d      = occ_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (bus.io_redirect_valid) begin
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            drop_d     = outst_q - CW'(resp_fire);
            occ_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (resp_fire && drop_q != '0) drop_d = drop_q - 1'b1;
            if (enq) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = bump(wr_ptr_q);
            end
            if (deq) rd_ptr_d = bump(rd_ptr_q);
            occ_d = occ_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            occ_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            buf_pc_q[wr_ptr_q]   <= resp_pc_q;
            buf_inst_q[wr_ptr_q] <= bus.io_imem_resp_data;
        end
    end

    // Head is masked while empty so the decoder sees zeros after reset and flushes.
    assign bus.io_imem_req_valid = req_valid;
    assign bus.io_imem_req_addr  = fetch_pc_q;
    assign bus.io_out_valid      = out_valid;
    assign bus.io_out_inst       = out_valid ? buf_inst_q[rd_ptr_q] : '0;
    assign bus.io_out_pc         = out_valid ? buf_pc_q[rd_ptr_q] : '0;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the instruction decoder. It holds the program counter and issues in-order word requests to instruction memory. Returned instruction words are buffered with their PCs in a small FIFO and presented to the decoder over a valid/ready handshake. A redirect from execute (branch, jump or trap) flushes the buffer, discards in-flight responses and restarts fetch at the new PC.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `DEPTH`, 2, entries in the instruction buffer and maximum outstanding memory requests; legal range 2..8.

- `clock`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `io_imem_req_valid`  out  1  request present.
- `io_imem_req_ready`  in  1  memory accepts the request this cycle.
- `io_imem_req_addr`  out  32  word-aligned fetch address (`[1:0]`=0).
- `io_imem_resp_valid`  in  1  response word present; always accepted, returned in request order.
- `io_imem_resp_data`  in  32  instruction word.
- `io_redirect_valid`  in  1  flush and restart fetch.
- `io_redirect_pc`  in  32  restart address; bits `[1:0]` ignored (forced 0).
- `io_out_valid`  out  1  buffer head valid, goes to decoder.
- `io_out_ready`  in  1  decoder consumes the head.
- `io_out_inst`  out  32  head instruction, drives decoder `io_inst`.
- `io_out_pc`  out  32  PC of the head instruction.

## Operation
- State:
  - `fetch_pc` (next request address).
  - `resp_pc` (PC of next kept response).
  - `outstanding` count, 0..DEPTH.
  - `drop` count, 0..DEPTH.
  - FIFO of DEPTH {pc, inst} entries with occupancy `occ`.
  - Counter width is clog2(DEPTH+1).
- `deq` = `io_out_valid & io_out_ready`.
- Request rule: `io_imem_req_valid` = `!io_redirect_valid & (outstanding + occ - deq < DEPTH)`. This is a combinational path from `io_out_ready`.
  - Credit guarantees the FIFO never overflows.
- On a request handshake (`req_valid & req_ready`): `fetch_pc += 4`, `outstanding += 1`.
- On `io_imem_resp_valid`: `outstanding -= 1`. Then:
  - If `drop != 0`: `drop -= 1` and the word is discarded.
  - Otherwise: enqueue {`resp_pc`, data} and `resp_pc += 4`.
- `io_out_valid` = `occ != 0`. `io_out_inst`/`io_out_pc` are the FIFO head. Dequeue on `deq`.
- Redirect cycle:
  - `fetch_pc` and `resp_pc` load `{io_redirect_pc[31:2],2'b00}`.
  - FIFO cleared, so `occ` = 0 next cycle; any `deq` that cycle is irrelevant.
  - No request is issued.
  - A response arriving in the redirect cycle is discarded.
  - `drop` loads `outstanding - resp_valid`; `outstanding` updates normally.
  - Back-to-back redirects: the last one wins; `drop` is recomputed each time.
- Spurious `io_imem_resp_valid` with `outstanding == 0`: protocol violation. It is ignored and no counter wraps.
- PC arithmetic is modulo 2^32; `32'hFFFF_FFFC + 4` wraps to 0.

## Timing
- Reset (asynchronous assert):
  - `fetch_pc` = `resp_pc` = `RESET_PC`.
  - Counters 0, FIFO empty.
  - `io_imem_req_valid` = 0, `io_out_valid` = 0, `io_out_inst` = 0, `io_out_pc` = 0.
- Reset mid-operation discards all in-flight state. Responses to pre-reset requests must not arrive after release; memory is reset together with this block.
- First cycle after release: `io_imem_req_valid` = 1, `io_imem_req_addr` = `RESET_PC`.
- Latency: request accepted at cycle t, response at t+k (k ≥ 1), `io_out_valid` at t+k+1. Responses are registered with no bypass.
- Throughput: with k = 1, `req_ready` = 1 and `out_ready` = 1, one instruction per cycle is sustained from cycle 2 onward.
- Redirect at cycle r: the first request to the new PC is at r+1. No stale instruction appears on `io_out_*` at or after r+1.
- Full FIFO with `out_ready` = 0: requests stop. They resume in the same cycle that `out_ready` rises.

## Test plan
- Reset release, `RESET_PC`=0x100, k=1, both readies high -> addrs 0x100, 0x104, 0x108…; `io_out_pc` 0x100 at cycle 2, then one instruction per cycle.
- `io_out_ready` held low for 10 cycles -> exactly DEPTH requests issued, `occ`=DEPTH; on release the head pc is 0x100 and requests resume that same cycle.
- k=3 latency, two requests in flight, redirect to 0x2002 -> both old responses dropped; next request addr 0x2000; first `io_out_pc`=0x2000 with its inst.
- Redirect in the same cycle as a response and with a full FIFO -> response discarded, `io_out_valid`=0 next cycle, no request in the redirect cycle.
- Redirect to 0xFFFF_FFFC -> fetch addrs 0xFFFF_FFFC then 0x0000_0000; `io_out_pc` matches.
- Reset asserted with requests outstanding and FIFO occupied -> all outputs at reset values immediately (asynchronous); fetch restarts at `RESET_PC` after release.
